// File: rtl/pad_in_filter.sv
// Synchronizing deglitch receiver for asynchronous pad inputs.
// Edge strobes are built only when PAD_IN_FILTER_EDGE_EN is defined.
module pad_in_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_CNT  = 8,
  parameter int   FILTER_W    = 4,
  parameter int   GLITCH_W    = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pad_di,
  input  logic                bypass,
  input  logic                glitch_clr,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [FILTER_W-1:0] CNT_MAX =
    FILTER_W'(FILTER_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_W-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic [GLITCH_W-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic                   glitch;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Pure shift chain: no logic between stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_di};
  end

  // Filter: a new level must persist FILTER_CNT cycles.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    glitch  = 1'b0;
    if (bypass) begin
      level_d = s;
      cnt_d   = '0;
    end else if (s == level_q) begin
      if (cnt_q != '0) begin
        cnt_d  = '0;
        glitch = 1'b1;
      end
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + FILTER_W'(1);
    end
  end

  // Saturating glitch counter; clear beats a same-edge glitch.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (glitch && !(&glitch_cnt_q)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
    end
  end

  // Synchronizer, filter and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= {SYNC_STAGES{RESET_VAL}};
      cnt_q        <= '0;
      level_q      <= RESET_VAL;
      glitch_cnt_q <= '0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign level      = level_q;
  assign glitch_cnt = glitch_cnt_q;

`ifdef PAD_IN_FILTER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes coincide with the first cycle of the new level.
  always_comb begin
    rise_d = ~level_q & level_d;
    fall_d = level_q & ~level_d;
  end

  // Strobe registers; reset exit never produces a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: doc/pad_in_filter.md
# pad_in_filter

Synchronizing deglitch receiver that sits directly behind a `pad_in` cell on every asynchronous chip input (resets excluded). It brings the raw pad level into the core clock domain and suppresses pulses shorter than a programmable number of cycles. It delivers a clean level plus optional one-cycle edge strobes, and counts rejected glitches for board-level diagnostics.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count, legal range 2..4.
- `FILTER_CNT`, 8: consecutive cycles a new level must persist before it is accepted, legal range 1..(2^`FILTER_W`).
- `FILTER_W`, 4: filter counter width.
- `GLITCH_W`, 8: glitch counter width.
- `RESET_VAL`, 1'b0: reset level of the synchronizer chain and of `level`.

Ports:
- `clk` input 1: core clock.
- `rst_n` input 1: asynchronous active-low reset.
- `pad_di` input 1: raw level from the `pad_in` `DataIn` pin; asynchronous.
- `bypass` input 1: 1 = skip the filter; `level` follows the synchronizer output.
- `glitch_clr` input 1: synchronous clear of `glitch_cnt`.
- `level` output 1: filtered, synchronized pad level.
- `rise` output 1: one-cycle strobe when `level` goes 0->1.
- `fall` output 1: one-cycle strobe when `level` goes 1->0.
- `glitch_cnt` output `GLITCH_W`: saturating count of rejected transitions.

## Operation
- **Synchronizer.** `SYNC_STAGES` flops in series, all reset to `RESET_VAL`. `s` is the last stage. No logic is allowed between stages.
- **Filter state.** The filter holds `cnt` (`FILTER_W` bits, reset 0) and `level` (reset `RESET_VAL`). Each clock edge, when `bypass`=0:
  - If `s`==`level` and `cnt`!=0: clear `cnt` to 0 and count one glitch.
  - If `s`==`level` and `cnt`==0: no change.
  - If `s`!=`level` and `cnt`==`FILTER_CNT`-1: `level` <= `s`, `cnt` <= 0.
  - If `s`!=`level` otherwise: `cnt` <= `cnt`+1.
- **Bypass.** When `bypass`=1, `level` <= `s` every cycle, `cnt` is held at 0, and no glitches are counted. Switching `bypass` in either direction mid-count drops the partial count without counting a glitch.
- **Edge strobes.** `rise`/`fall` are registered and reset to 0. They assert at the same edge where `level` changes, for exactly one cycle, in both filtered and bypass modes. `rise` and `fall` are never asserted together.
- **Glitch counter.** `glitch_cnt` resets to 0 and increments by one per glitch event. It saturates at 2^`GLITCH_W`-1 and never wraps. If `glitch_clr` and a glitch event occur on the same edge, the clear wins and the result is 0.
- **Reset mid-operation.** Reset returns every flop to its reset value immediately. No strobe is generated on reset exit, even when the pad level differs from `RESET_VAL`. That difference is treated as a normal transition and filtered.

## Timing
- **Filtered latency.** A pad change that is stable across edge E0 and onward appears on `s` after edge E0+`SYNC_STAGES`-1. `level` changes at edge E0+`SYNC_STAGES`-1+`FILTER_CNT`, which is 9 cycles with the defaults.
- **Bypass latency.** `level` changes at edge E0+`SYNC_STAGES`.
- **Minimum accepted pulse.** `FILTER_CNT` cycles. Shorter pulses, as seen at `s`, never reach `level`.
- **Strobe alignment.** Each strobe is coincident with the first cycle of the new `level`.
- **Glitch counter update.** `glitch_cnt` updates one edge after `s` returns to `level`.
- All outputs are flop-driven. There is no combinational path from inputs to outputs.

## Configuration
- **`PAD_IN_FILTER_EDGE_EN`** controls the edge-strobe logic.
- **Defined:** the `rise`/`fall` strobe logic is built as described above.
- **Undefined:** the strobe flops are not built, `rise` and `fall` are tied to 1'b0, and the port list is unchanged. Filter, bypass, and glitch-counter behaviour are identical in both builds.

## Test plan
- **Reset and clean transition.** Release reset with `pad_di`=0 and defaults, then raise `pad_di` and hold it. Required: `level` rises exactly 9 edges later, `rise`=1 for one cycle, `glitch_cnt`=0.
- **Short pulse.** Drive a 5-cycle high pulse with `level`=0 and `FILTER_CNT`=8. Required: `level` stays 0, no strobe, `glitch_cnt`=1.
- **Boundary pulses.** A pulse of exactly `FILTER_CNT` cycles at `s` is accepted: `level` goes 1 then 0, with one `rise` and one `fall`. A pulse of `FILTER_CNT`-1 cycles is rejected and `glitch_cnt` increments.
- **Bypass.** Set `bypass`=1 and toggle `pad_di` every 3 cycles. Required: `level` tracks the toggles with 2-cycle latency and one strobe per change. Assert `bypass` while `cnt`=4: `cnt` drops to 0 and `glitch_cnt` is unchanged.
- **Saturation and clear.** With `GLITCH_W`=2, inject 5 glitches. Required: `glitch_cnt` reads 3. Pulse `glitch_clr` on the same edge as a glitch event: required result is 0.
- **Async reset mid-count.** Assert `rst_n`=0 while `cnt`=6 and `level`=1 (with `RESET_VAL`=0). Required: all outputs go to reset values with no clock edge. After release with `pad_di`=1, `level` returns to 1 after 9 edges with a single `rise`. Rebuild without `PAD_IN_FILTER_EDGE_EN`: `rise`/`fall` stay 0 throughout.
